// File: rtl/half_duplex_pkg.sv
// ---------------------------------------------------------------------------
// half_duplex_pkg
// Shared definitions for the half-duplex word transceiver.
//   hdp_state_e  : ownership state machine encoding
//   sampled_high : shared-net sampling helper (only a clean 1 counts as 1)
// ---------------------------------------------------------------------------
package half_duplex_pkg;

    typedef enum logic [2:0] {
        ST_OWNER   = 3'd0,  // drives bus/strobe/pass, accepts local words
        ST_PASS    = 3'd1,  // one-cycle token handoff, may carry a last word
        ST_RELEASE = 3'd2,  // all nets released after handing the token away
        ST_LISTEN  = 3'd3,  // receives words, drives want
        ST_ACQUIRE = 3'd4   // all nets released before taking ownership
    } hdp_state_e;

    // A floating or contended shared net must never be mistaken for a
    // request or a handoff, so anything other than a clean 1 reads as 0.
    function automatic logic sampled_high(input logic v);
        return (v === 1'b1);
    endfunction

endpackage

// File: rtl/tri_buf.sv
// ---------------------------------------------------------------------------
// tri_buf
// Tristate driver for one shared net.
//   en : drive enable
//   d  : value driven when enabled
//   io : shared net, 'z when not enabled
// ---------------------------------------------------------------------------
module tri_buf #(
    parameter int WIDTH = 1
) (
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    inout  wire  [WIDTH-1:0] io
);

    assign io = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/half_duplex_port.sv
// ---------------------------------------------------------------------------
// half_duplex_port
// One end of a half-duplex word link over shared tristate nets. The two ends
// pass an ownership token with TURNAROUND released cycles between owners.
//   clk, reset_n        : clock, synchronous active-low reset
//   tx_valid/tx_data    : local word to send
//   tx_ready            : local word accepted when tx_valid && tx_ready
//   rx_valid/rx_data    : one-cycle pulse per received word
//   is_owner            : high while this end owns the bus (OWNER or PASS)
//   bus/strobe/pass/want: shared nets (data, data-valid, token, request)
// ---------------------------------------------------------------------------
module half_duplex_port
    import half_duplex_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 1,
    parameter int MAX_BURST  = 4,
    parameter int INIT_OWNER = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             is_owner,
    inout  wire  [WIDTH-1:0] bus,
    inout  wire              strobe,
    inout  wire              pass,
    inout  wire              want
);

    localparam int BW   = $clog2(MAX_BURST + 1);
    localparam int TA_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam hdp_state_e RESET_STATE = (INIT_OWNER != 0) ? ST_OWNER : ST_LISTEN;

    hdp_state_e      state_reg, state_next;
    logic [BW-1:0]   burst_cnt_reg, burst_cnt_next;
    logic [TA_W-1:0] ta_cnt_reg, ta_cnt_next;

    // Registered shared-net values and enables.
    logic             bus_en_reg, strobe_en_reg, pass_en_reg, want_en_reg;
    logic [WIDTH-1:0] bus_q_reg;
    logic             strobe_q_reg, pass_q_reg, want_q_reg;

    logic             rx_valid_reg;
    logic [WIDTH-1:0] rx_data_reg;

    logic handshake;
    logic want_seen, pass_seen, strobe_seen;
    logic burst_at_limit, ta_done, owner_next;

    assign want_seen   = sampled_high(want);
    assign pass_seen   = sampled_high(pass);
    assign strobe_seen = sampled_high(strobe);

    // Gated with reset_n so the port never accepts a word while reset is held.
    assign tx_ready  = reset_n && (state_reg == ST_OWNER);
    assign handshake = tx_valid && tx_ready;
    assign is_owner  = (state_reg == ST_OWNER) || (state_reg == ST_PASS);

    // True when the handshake in this cycle is the last one allowed while
    // the peer is waiting.
    assign burst_at_limit = (burst_cnt_reg >= BW'(MAX_BURST - 1));
    assign ta_done        = (ta_cnt_reg == TA_W'(TURNAROUND - 1));

    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        ta_cnt_next    = ta_cnt_reg;
        case (state_reg)
            ST_OWNER: begin
                if (handshake && (burst_cnt_reg < BW'(MAX_BURST))) begin
                    burst_cnt_next = burst_cnt_reg + BW'(1);
                end
                if (want_seen && (!handshake || burst_at_limit)) begin
                    state_next = ST_PASS;
                end
            end
            ST_PASS: begin
                state_next  = ST_RELEASE;
                ta_cnt_next = '0;
            end
            ST_RELEASE: begin
                if (ta_done) begin
                    state_next  = ST_LISTEN;
                    ta_cnt_next = '0;
                end else begin
                    ta_cnt_next = ta_cnt_reg + TA_W'(1);
                end
            end
            ST_LISTEN: begin
                if (pass_seen) begin
                    state_next  = ST_ACQUIRE;
                    ta_cnt_next = '0;
                end
            end
            ST_ACQUIRE: begin
                if (ta_done) begin
                    state_next     = ST_OWNER;
                    burst_cnt_next = '0;
                    ta_cnt_next    = '0;
                end else begin
                    ta_cnt_next = ta_cnt_reg + TA_W'(1);
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    // Drive enables follow the state being entered, so every net changes
    // driver exactly on the state boundary and the released window is
    // exactly TURNAROUND cycles long.
    assign owner_next = (state_next == ST_OWNER) || (state_next == ST_PASS);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= RESET_STATE;
            burst_cnt_reg <= '0;
            ta_cnt_reg    <= '0;
            bus_en_reg    <= 1'b0;
            strobe_en_reg <= 1'b0;
            pass_en_reg   <= 1'b0;
            want_en_reg   <= 1'b0;
            bus_q_reg     <= '0;
            strobe_q_reg  <= 1'b0;
            pass_q_reg    <= 1'b0;
            want_q_reg    <= 1'b0;
            rx_valid_reg  <= 1'b0;
            rx_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            ta_cnt_reg    <= ta_cnt_next;

            bus_en_reg    <= owner_next;
            strobe_en_reg <= owner_next;
            pass_en_reg   <= owner_next;
            want_en_reg   <= (state_next == ST_LISTEN);

            // The accepted word goes out on the following cycle, which may
            // already be PASS; the bus keeps its last value while idle.
            if (handshake) begin
                bus_q_reg <= tx_data;
            end
            strobe_q_reg <= handshake;
            pass_q_reg   <= (state_next == ST_PASS);
            want_q_reg   <= tx_valid;

            // Only LISTEN delivers; a word seen alongside pass is still
            // delivered in the first ACQUIRE cycle.
            rx_valid_reg <= (state_reg == ST_LISTEN) && strobe_seen;
            if ((state_reg == ST_LISTEN) && strobe_seen) begin
                rx_data_reg <= bus;
            end
        end
    end

    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;

    tri_buf #(.WIDTH(WIDTH)) u_bus_buf (
        .en (bus_en_reg),
        .d  (bus_q_reg),
        .io (bus)
    );

    tri_buf #(.WIDTH(1)) u_strobe_buf (
        .en (strobe_en_reg),
        .d  (strobe_q_reg),
        .io (strobe)
    );

    tri_buf #(.WIDTH(1)) u_pass_buf (
        .en (pass_en_reg),
        .d  (pass_q_reg),
        .io (pass)
    );

    tri_buf #(.WIDTH(1)) u_want_buf (
        .en (want_en_reg),
        .d  (want_q_reg),
        .io (want)
    );

endmodule

// File: tb/tb_half_duplex_port.sv
// ---------------------------------------------------------------------------
// tb_half_duplex_port
// Two half_duplex_port ends (A owns after reset, B listens) on shared nets
// with weak pull-downs. Directed vectors plus hand-timed handoff sequences.
// ---------------------------------------------------------------------------
module tb_half_duplex_port;
    import half_duplex_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         a_tx_valid, b_tx_valid;
    logic [W-1:0] a_tx_data, b_tx_data;
    logic         a_tx_ready, b_tx_ready;
    logic         a_rx_valid, b_rx_valid;
    logic [W-1:0] a_rx_data, b_rx_data;
    logic         a_is_owner, b_is_owner;

    wire [W-1:0] bus;
    wire         strobe;
    wire         pass;
    wire         want;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bus_pd
            pulldown pd_bus (bus[gi]);
        end
    endgenerate
    pulldown pd_strobe (strobe);
    pulldown pd_pass (pass);
    pulldown pd_want (want);

    always #5 clk = ~clk;

    half_duplex_port #(.WIDTH(W), .TURNAROUND(2), .MAX_BURST(4), .INIT_OWNER(1)) u_a (
        .clk(clk), .reset_n(reset_n),
        .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
        .rx_valid(a_rx_valid), .rx_data(a_rx_data), .is_owner(a_is_owner),
        .bus(bus), .strobe(strobe), .pass(pass), .want(want)
    );

    half_duplex_port #(.WIDTH(W), .TURNAROUND(2), .MAX_BURST(4), .INIT_OWNER(0)) u_b (
        .clk(clk), .reset_n(reset_n),
        .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data), .is_owner(b_is_owner),
        .bus(bus), .strobe(strobe), .pass(pass), .want(want)
    );

    wire a_any = u_a.bus_en_reg | u_a.strobe_en_reg | u_a.pass_en_reg | u_a.want_en_reg;
    wire b_any = u_b.bus_en_reg | u_b.strobe_en_reg | u_b.pass_en_reg | u_b.want_en_reg;
    wire clash = (u_a.bus_en_reg & u_b.bus_en_reg) | (u_a.strobe_en_reg & u_b.strobe_en_reg)
               | (u_a.pass_en_reg & u_b.pass_en_reg) | (u_a.want_en_reg & u_b.want_en_reg);

    int checks   = 0;
    int failures = 0;
    int clash_cnt = 0;
    int unk_cnt   = 0;
    bit mon_on    = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (clash) clash_cnt++;
            if ($isunknown({bus, strobe, pass, want})) unk_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic         a_v;
        logic [W-1:0] a_d;
        logic         exp_a_ready;
        logic         exp_b_rx_valid;
        logic [W-1:0] exp_b_rx_data;
        logic         exp_a_owner;
        logic         exp_b_owner;
    } vec_t;

    vec_t vecs[6];

    logic [W-1:0] q_ab[$];
    logic [W-1:0] q_ba[$];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit hs_a, hs_b, prev_a_owner, prev_b_owner, draining;
        int run_a, run_b, sent_a, sent_b, recv_a, recv_b;
        logic [W-1:0] exp_w;

        reset_n    = 1'b0;
        a_tx_valid = 1'b0;
        b_tx_valid = 1'b0;
        a_tx_data  = '0;
        b_tx_data  = '0;

        //           a_v   a_d    a_rdy b_rxv b_rxd  a_own b_own
        vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

        // Reset held for 3 cycles: nothing driven, reset output values.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_a_drive", a_any, 0);
            check("rst_b_drive", b_any, 0);
            check("rst_a_tx_ready", a_tx_ready, 0);
            check("rst_b_rx_valid", b_rx_valid, 0);
            check("rst_b_rx_data", b_rx_data, 0);
            check("rst_a_rx_valid", a_rx_valid, 0);
            check("rst_a_owner", a_is_owner, 1);
            check("rst_b_owner", b_is_owner, 0);
            $display("reset cycle %0d a_owner=%0b b_owner=%0b", i, a_is_owner, b_is_owner);
        end
        reset_n = 1'b1;
        mon_on  = 1'b1;

        // A streams 0x11, 0x22, 0x33 back-to-back; B only listens.
        for (int i = 0; i < 6; i++) begin
            a_tx_valid = vecs[i].a_v;
            a_tx_data  = vecs[i].a_d;
            #1;
            check("vec_a_tx_ready", a_tx_ready, vecs[i].exp_a_ready);
            check("vec_b_tx_ready", b_tx_ready, 0);
            check("vec_b_rx_valid", b_rx_valid, vecs[i].exp_b_rx_valid);
            if (vecs[i].exp_b_rx_valid) check("vec_b_rx_data", b_rx_data, vecs[i].exp_b_rx_data);
            check("vec_a_owner", a_is_owner, vecs[i].exp_a_owner);
            check("vec_b_owner", b_is_owner, vecs[i].exp_b_owner);
            $display("vec %0d a_v=%0b a_d=%h b_rx_valid=%0b b_rx_data=%h", i,
                     vecs[i].a_v, vecs[i].a_d, b_rx_valid, b_rx_data);
            step();
        end

        // Handoff to B: A idle, B presents 0xAB (PASS in cycle s+2).
        b_tx_valid = 1'b1;
        b_tx_data  = 8'hAB;
        #1;
        check("ho_a_owner_s0", a_is_owner, 1);
        step();
        check("ho_want_s1", want, 1);
        check("ho_a_ready_s1", a_tx_ready, 1);
        step();
        check("ho_pass_s2", pass, 1);
        check("ho_a_ready_s2", a_tx_ready, 0);
        check("ho_a_owner_s2", a_is_owner, 1);
        for (int k = 3; k <= 4; k++) begin
            step();
            check("ho_a_released", a_any, 0);
            check("ho_b_released", b_any, 0);
            check("ho_a_owner_ta", a_is_owner, 0);
            check("ho_b_owner_ta", b_is_owner, 0);
        end
        step();
        check("ho_b_owner_s5", b_is_owner, 1);
        check("ho_b_ready_s5", b_tx_ready, 1);
        step();
        b_tx_valid = 1'b0;
        check("ho_strobe_s6", strobe, 1);
        check("ho_bus_s6", bus, 8'hAB);
        step();
        check("ho_a_rx_valid_s7", a_rx_valid, 1);
        check("ho_a_rx_data_s7", a_rx_data, 8'hAB);
        $display("handoff word a_rx_data=%h", a_rx_data);
        step();
        check("ho_a_rx_valid_s8", a_rx_valid, 0);

        // B's burst limit lands its last word in the PASS cycle.
        a_tx_valid = 1'b1;
        a_tx_data  = 8'hE0;
        b_tx_valid = 1'b1;
        b_tx_data  = 8'hC1;
        #1;
        check("lw_b_ready_u0", b_tx_ready, 1);
        step();
        b_tx_data = 8'hC2;
        step();
        b_tx_data = 8'hC3;
        check("lw_a_rx_valid_u2", a_rx_valid, 1);
        check("lw_a_rx_data_u2", a_rx_data, 8'hC1);
        step();
        b_tx_valid = 1'b0;
        check("lw_pass_u3", pass, 1);
        check("lw_strobe_u3", strobe, 1);
        check("lw_bus_u3", bus, 8'hC3);
        check("lw_a_rx_data_u3", a_rx_data, 8'hC2);
        check("lw_b_ready_u3", b_tx_ready, 0);
        step();
        a_tx_valid = 1'b0;
        check("lw_a_rx_valid_u4", a_rx_valid, 1);
        check("lw_a_rx_data_u4", a_rx_data, 8'hC3);
        check("lw_a_acquire_u4", 32'(u_a.state_reg), 32'(ST_ACQUIRE));
        $display("last word with pass a_rx_data=%h", a_rx_data);
        step();
        check("lw_a_acquire_u5", 32'(u_a.state_reg), 32'(ST_ACQUIRE));
        check("lw_a_rx_valid_u5", a_rx_valid, 0);
        step();
        check("lw_a_owner_u6", a_is_owner, 1);
        check("lw_b_owner_u6", b_is_owner, 0);

        // Reset in the middle of a burst discards the in-flight word.
        do_reset();
        a_tx_valid = 1'b1;
        a_tx_data  = 8'h55;
        #1;
        step();
        a_tx_data = 8'h66;
        check("mr_strobe_r1", strobe, 1);
        check("mr_bus_r1", bus, 8'h55);
        reset_n    = 1'b0;
        a_tx_valid = 1'b0;
        step();
        check("mr_a_released", a_any, 0);
        check("mr_b_released", b_any, 0);
        check("mr_b_rx_valid_r2", b_rx_valid, 0);
        step();
        check("mr_b_rx_valid_r3", b_rx_valid, 0);
        reset_n = 1'b1;
        step();
        check("mr_a_owner", a_is_owner, 1);
        check("mr_b_owner", b_is_owner, 0);
        check("mr_a_ready", a_tx_ready, 1);
        check("mr_b_rx_valid_r4", b_rx_valid, 0);
        $display("mid-burst reset done a_owner=%0b b_owner=%0b", a_is_owner, b_is_owner);

        // Both ends always valid: rounds of exactly 4 words, scoreboarded.
        do_reset();
        a_tx_valid   = 1'b1;
        b_tx_valid   = 1'b1;
        a_tx_data    = 8'h10;
        b_tx_data    = 8'h80;
        prev_a_owner = 1'b1;
        prev_b_owner = 1'b0;
        draining     = 1'b0;
        run_a = 0; run_b = 0; sent_a = 0; sent_b = 0; recv_a = 0; recv_b = 0;
        #1;
        for (int cyc = 0; cyc < 90; cyc++) begin
            hs_a = a_tx_valid && a_tx_ready;
            hs_b = b_tx_valid && b_tx_ready;
            if (hs_a) begin q_ab.push_back(a_tx_data); sent_a++; run_a++; end
            if (hs_b) begin q_ba.push_back(b_tx_data); sent_b++; run_b++; end
            if (b_rx_valid) begin
                recv_b++;
                check("burst_b_rx_expected", 32'(q_ab.size() != 0), 1);
                if (q_ab.size() != 0) begin
                    exp_w = q_ab.pop_front();
                    check("burst_b_rx_data", b_rx_data, exp_w);
                end
                $display("burst B rx %h", b_rx_data);
            end
            if (a_rx_valid) begin
                recv_a++;
                check("burst_a_rx_expected", 32'(q_ba.size() != 0), 1);
                if (q_ba.size() != 0) begin
                    exp_w = q_ba.pop_front();
                    check("burst_a_rx_data", a_rx_data, exp_w);
                end
                $display("burst A rx %h", a_rx_data);
            end
            if (prev_a_owner && !a_is_owner) begin
                if (!draining) check("burst_a_round_len", run_a, 4);
                run_a = 0;
            end
            if (prev_b_owner && !b_is_owner) begin
                if (!draining) check("burst_b_round_len", run_b, 4);
                run_b = 0;
            end
            prev_a_owner = a_is_owner;
            prev_b_owner = b_is_owner;
            if (cyc == 76) begin
                a_tx_valid = 1'b0;
                b_tx_valid = 1'b0;
                draining   = 1'b1;
            end
            step();
            if (hs_a) a_tx_data = a_tx_data + 8'd1;
            if (hs_b) b_tx_data = b_tx_data + 8'd1;
        end
        check("burst_q_ab_empty", q_ab.size(), 0);
        check("burst_q_ba_empty", q_ba.size(), 0);
        check("burst_count_ab", recv_b, sent_a);
        check("burst_count_ba", recv_a, sent_b);
        check("burst_a_progress", 32'(sent_a >= 8), 1);
        check("burst_b_progress", 32'(sent_b >= 8), 1);
        check("no_collision", clash_cnt, 0);
        check("no_unknown", unk_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/half_duplex_port.md
# half_duplex_port

Half-duplex word transceiver for one end of a shared bidirectional (inout) bus. Two instances, one per end, share the same `bus`, `strobe`, `pass` and `want` nets. The ownership token moves between them with explicit tristate turnaround cycles, so only one end drives at a time. The block is the active endpoint for the cosim inout-net tests: local streaming tx/rx ports on one side, shared tristate nets on the other.

## Interface
- `WIDTH`, default 8: data word width.
- `TURNAROUND`, default 1 (≥1): cycles during which neither end drives after a handoff.
- `MAX_BURST`, default 4 (≥1): words the owner may send while the peer requests ownership.
- `INIT_OWNER`, default 0: 1 means this end owns the bus after reset.
- `clk`  in  1: clock; all logic on rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `tx_valid`  in  1: local word available.
- `tx_data`  in  WIDTH: local word.
- `tx_ready`  out  1: word accepted this cycle when `tx_valid && tx_ready`.
- `rx_valid`  out  1: one-cycle pulse per received word; no backpressure.
- `rx_data`  out  WIDTH: received word, valid while `rx_valid` is high.
- `is_owner`  out  1: high in OWNER or PASS.
- `bus`  inout  WIDTH: shared data.
- `strobe`  inout  1: shared; high means `bus` carries a word.
- `pass`  inout  1: shared; one-cycle token handoff.
- `want`  inout  1: shared; driven only by the non-owner, high means it has data.

## Operation
- States: OWNER, PASS, RELEASE, LISTEN, ACQUIRE. Reset state is OWNER if `INIT_OWNER`, else LISTEN.
- Every shared-net value and its drive enable is registered. Disabled nets are `'z`.
- A sampled shared-net value other than 1 (including z/x) is treated as 0.
- OWNER:
  - Drives `bus`, `strobe` and `pass=0`; `want` is released.
  - `tx_ready=1`. On handshake, the next cycle drives `bus=tx_data` and `strobe=1`, and `burst_cnt` increments (saturates at `MAX_BURST`). With no handshake, the next cycle drives `strobe=0`.
  - Goes to PASS when sampled `want==1` and either no handshake this cycle or `burst_cnt` reaches `MAX_BURST` with this handshake.
- PASS (1 cycle):
  - `tx_ready=0`; drives `pass=1`.
  - `strobe` and `bus` carry the word from the final handshake, if any. A last word and `pass` in the same cycle is legal.
  - Next state is RELEASE.
- RELEASE: all shared nets released for `TURNAROUND` cycles, then LISTEN.
- LISTEN:
  - Drives `want=tx_valid`; `tx_ready=0`.
  - Sampled `strobe==1` produces `rx_valid=1` and `rx_data=bus` in the next cycle.
  - Sampled `pass==1` moves to ACQUIRE. Data sampled in that same cycle is still delivered.
- ACQUIRE:
  - All nets released for `TURNAROUND` cycles, then OWNER with `burst_cnt=0`.
  - `rx_valid` stays 0, except for the delivery pending from LISTEN.
- An owner with an empty queue and `want==0` stays in OWNER indefinitely, driving `strobe=0`.

## Timing
- Reset values: all drive enables 0, `tx_ready=0`, `rx_valid=0`, `rx_data=0`, `is_owner=INIT_OWNER`, `burst_cnt=0`, turnaround counter 0.
- Reset behaviour: reset sampled low releases all nets at that edge. Asserting reset mid-burst discards the in-flight word. Both ends must be reset together.
- tx-to-rx latency: handshake in cycle c → `strobe` in c+1 → `rx_valid` in c+2.
- Handoff, with PASS in cycle t:
  - Owner is in RELEASE for t+1..t+TURNAROUND and in LISTEN from t+TURNAROUND+1.
  - Peer is in ACQUIRE for t+1..t+TURNAROUND and in OWNER from t+TURNAROUND+1.
  - Shared nets are undriven for exactly `TURNAROUND` cycles; the two ends never drive simultaneously.
- Sustained owner throughput is 1 word/cycle.
- Each ownership round costs `TURNAROUND`+1 cycles with `tx_ready=0`.

## Structure
- `half_duplex_pkg`: `hdp_state_e` state enum.
- Sub-module `tri_buf #(WIDTH)`: input `en`, input `d`, inout `io`; drives `io = en ? d : 'z`. Instantiate it once per shared net.
- Benches connect two `half_duplex_port` instances (INIT_OWNER 1 and 0) on common wires, with weak pull-downs on all shared nets.

## Test plan
- Reset held 3 cycles → all shared nets z during reset; after release A `is_owner=1`, B `is_owner=0`.
- A sends 0x11, 0x22, 0x33 back-to-back with B `tx_valid=0` → B `rx_valid` pulses 3 consecutive cycles starting 2 cycles after the first handshake, data in order; A stays OWNER.
- `TURNAROUND=2`, A idle, B presents 0xAB → A PASS, 2 cycles with all nets z, B becomes OWNER, A receives 0xAB 2 cycles after B's handshake.
- `MAX_BURST=4`, both ends always valid → ownership alternates after every 4 words; no x ever appears on `bus`/`strobe`; word counts match on both sides.
- Last word's `strobe` coincides with `pass` → receiver delivers the word and enters ACQUIRE.
- Reset asserted mid-burst → nets released next edge, no `rx_valid`; after release ownership returns to INIT_OWNER.
